// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: hold codes, bus widths, jump enable,
// reset PC constant and the fetch FSM state type.
package pc_fetch_pkg;

    localparam int          HOLD_CTRL_BUS_W  = 8;
    localparam int          INST_ADDR_BUS_W  = 32;
    localparam logic        JUMP_ENABLE      = 1'b1;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        HOLD_NO    = 2'b00,
        HOLD_WAIT  = 2'b01,
        HOLD_FLUSH = 2'b10
    } hold_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_DISCARD
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC sequencing, single-entry hold buffer and jump redirect.
// Optional bus-timeout detector enabled by defining PC_FETCH_TIMEOUT_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [HOLD_CTRL_BUS_W-1:0] hold_ctrl_i,
    input  logic                       jump_flag_i,
    input  logic [INST_ADDR_BUS_W-1:0] jump_addr_i,
    output logic                       ibus_req_o,
    output logic [INST_ADDR_BUS_W-1:0] ibus_addr_o,
    input  logic                       ibus_ack_i,
    input  logic [31:0]                ibus_rdata_i,
    output logic [31:0]                inst_o,
    output logic [INST_ADDR_BUS_W-1:0] inst_addr_o,
    output logic                       inst_valid_o,
    output logic                       fetch_err_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_addr_q, pend_addr_d;
    logic [31:0]  buf_inst_q, buf_inst_d;
    logic [31:0]  buf_addr_q, buf_addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_addr_q, inst_addr_d;
    logic         inst_valid_q, inst_valid_d;
    logic         fetch_err_q, fetch_err_d;

    logic         jump;
    logic         stall;
    logic [31:0]  jump_target;
    logic [31:0]  pc_next;

    // Only the PC hold field matters to this stage.
    logic unused_hold;
    assign unused_hold = ^hold_ctrl_i[HOLD_CTRL_BUS_W-1:2];

    assign jump        = jump_flag_i & JUMP_ENABLE;
    assign stall       = (hold_ctrl_i[1:0] == HOLD_WAIT);
    assign jump_target = word_align(jump_addr_i);
    assign pc_next     = pc_q + 32'd4;

    always_comb begin
        // NOTE: every _d defaults to its _q (strobe to 0) so no branch can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        pend_addr_d  = pend_addr_q;
        buf_inst_d   = buf_inst_q;
        buf_addr_d   = buf_addr_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (jump) begin
                    pc_d = jump_target;
                end
                if (!stall) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (ibus_ack_i) begin
                    if (jump) begin
                        pc_d = jump_target;
                    end else if (stall) begin
                        buf_inst_d = ibus_rdata_i;
                        buf_addr_d = pc_q;
                        pc_d       = pc_next;
                        state_d    = ST_HOLD;
                    end else begin
                        inst_d       = ibus_rdata_i;
                        inst_addr_d  = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_next;
                    end
                end else if (jump) begin
                    // The bus still owns the old address; remember where to go once it acks.
                    pend_addr_d = jump_target;
                    state_d     = ST_DISCARD;
                end
            end

            ST_HOLD: begin
                if (jump) begin
                    pc_d    = jump_target;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    inst_d       = buf_inst_q;
                    inst_addr_d  = buf_addr_q;
                    inst_valid_d = 1'b1;
                    state_d      = ST_REQ;
                end
            end

            ST_DISCARD: begin
                if (ibus_ack_i) begin
                    pc_d    = jump ? jump_target : pend_addr_q;
                    state_d = ST_REQ;
                end else if (jump) begin
                    pend_addr_d = jump_target;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PC_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter saturates at the threshold; the error flag is sticky until reset.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        fetch_err_d = fetch_err_q;
        if (ibus_req_o) begin
            if (ibus_ack_i) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end
        if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            fetch_err_d = 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign fetch_err_d    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= word_align(RESET_PC);
            pend_addr_q  <= '0;
            // NOTE: the one-entry buffer is plain flops, so it is reset along with everything else.
            buf_inst_q   <= '0;
            buf_addr_q   <= '0;
            inst_q       <= '0;
            inst_addr_q  <= '0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            buf_inst_q   <= buf_inst_d;
            buf_addr_q   <= buf_addr_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
`ifdef PC_FETCH_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign ibus_req_o   = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign ibus_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;
    assign fetch_err_o  = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam int unsigned TIMEOUT = 255;
    localparam logic [1:0]  H_NO    = HOLD_NO;
    localparam logic [1:0]  H_WAIT  = HOLD_WAIT;
`ifdef PC_FETCH_TIMEOUT_EN
    localparam logic        TMO_EXP = 1'b1;
`else
    localparam logic        TMO_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hold_ctrl_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        fetch_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    pc_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_ctrl_i  (hold_ctrl_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_ack_i   (ibus_ack_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .fetch_err_o  (fetch_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a fetch "engine" that is either not yet started, parked on a
    // full buffer, waiting out a cancelled fetch, or streaming requests.
    logic [31:0] m_pc, m_inst, m_inst_addr, m_buf_inst, m_buf_addr, m_redir_addr;
    logic        m_started, m_buf_full, m_redirect, m_valid, m_err;
    int          m_tmo;

    function automatic void model_reset();
        m_pc         = 32'h0;
        m_inst       = 32'h0;
        m_inst_addr  = 32'h0;
        m_buf_inst   = 32'h0;
        m_buf_addr   = 32'h0;
        m_redir_addr = 32'h0;
        m_started    = 1'b0;
        m_buf_full   = 1'b0;
        m_redirect   = 1'b0;
        m_valid      = 1'b0;
        m_err        = 1'b0;
        m_tmo        = 0;
    endfunction

    function automatic void emit(input logic [31:0] data, input logic [31:0] addr);
        m_inst      = data;
        m_inst_addr = addr;
        m_valid     = 1'b1;
    endfunction

    function automatic void model_step();
        logic        stall;
        logic        requesting;
        logic [31:0] tgt;
        if (rst) begin
            model_reset();
            return;
        end
        stall      = (hold_ctrl_i[1:0] == H_WAIT);
        tgt        = jump_addr_i & 32'hFFFF_FFFC;
        requesting = m_started && !m_buf_full;
        m_valid    = 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
        if (requesting) begin
            if (ibus_ack_i) m_tmo = 0;
            else if (m_tmo < int'(TIMEOUT)) m_tmo++;
        end
        if (m_tmo == int'(TIMEOUT)) m_err = 1'b1;
`endif
        if (!m_started) begin
            if (jump_flag_i) m_pc = tgt;
            if (!stall) m_started = 1'b1;
        end else if (m_buf_full) begin
            if (jump_flag_i) begin
                m_buf_full = 1'b0;
                m_pc       = tgt;
            end else if (!stall) begin
                emit(m_buf_inst, m_buf_addr);
                m_buf_full = 1'b0;
            end
        end else if (m_redirect) begin
            if (ibus_ack_i) begin
                m_pc       = jump_flag_i ? tgt : m_redir_addr;
                m_redirect = 1'b0;
            end else if (jump_flag_i) begin
                m_redir_addr = tgt;
            end
        end else if (ibus_ack_i) begin
            if (jump_flag_i) begin
                m_pc = tgt;
            end else if (stall) begin
                m_buf_inst = ibus_rdata_i;
                m_buf_addr = m_pc;
                m_buf_full = 1'b1;
                m_pc       = m_pc + 32'd4;
            end else begin
                emit(ibus_rdata_i, m_pc);
                m_pc = m_pc + 32'd4;
            end
        end else if (jump_flag_i) begin
            m_redirect   = 1'b1;
            m_redir_addr = tgt;
        end
    endfunction

    // Compare process: every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_bit("ibus_req_o",   ibus_req_o,   m_started && !m_buf_full);
            check    ("ibus_addr_o",  ibus_addr_o,  m_pc);
            check_bit("inst_valid_o", inst_valid_o, m_valid);
            check    ("inst_o",       inst_o,       m_inst);
            check    ("inst_addr_o",  inst_addr_o,  m_inst_addr);
            check_bit("fetch_err_o",  fetch_err_o,  m_err);
        end
    end

    // One clock: drive inputs, advance the model at the edge, return just after the falling edge.
    task automatic cycle(input logic jf, input logic [31:0] ja, input logic [1:0] hp, input logic ack);
        logic [5:0] hi;
        hi           = 6'($urandom());
        jump_flag_i  = jf;
        jump_addr_i  = ja;
        hold_ctrl_i  = {hi, hp};
        ibus_ack_i   = ack;
        ibus_rdata_i = $urandom();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, H_NO, 1'b1);
        rst = 1'b0;
    endtask

    logic [31:0] saved_rdata;

    initial begin
        rst          = 1'b1;
        hold_ctrl_i  = 8'h0;
        jump_flag_i  = 1'b0;
        jump_addr_i  = 32'h0;
        ibus_ack_i   = 1'b0;
        ibus_rdata_i = 32'h0;
        model_reset();
        @(negedge clk);
        #1;
        cmp_en = 1'b1;
        do_reset(2);

        check_bit("rst_req",   ibus_req_o,   1'b0);
        check_bit("rst_valid", inst_valid_o, 1'b0);
        check    ("rst_inst",  inst_o,       32'h0);
        check    ("rst_iaddr", inst_addr_o,  32'h0);
        check_bit("rst_err",   fetch_err_o,  1'b0);

        // Full-rate streaming from reset.
        cycle(1'b0, 32'h0, H_NO, 1'b0);
        check_bit("start_req",  ibus_req_o,  1'b1);
        check    ("start_addr", ibus_addr_o, 32'h0);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        saved_rdata = ibus_rdata_i;
        check_bit("s0_valid", inst_valid_o, 1'b1);
        check    ("s0_addr",  inst_addr_o,  32'h0);
        check    ("s0_data",  inst_o,       saved_rdata);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check_bit("s1_valid", inst_valid_o, 1'b1);
        check    ("s1_addr",  inst_addr_o,  32'h4);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check_bit("s2_valid", inst_valid_o, 1'b1);
        check    ("s2_addr",  inst_addr_o,  32'h8);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check    ("s3_addr",  inst_addr_o,  32'hC);
        check    ("pc_10",    ibus_addr_o,  32'h10);

        // Ack of 0x10 under a three-cycle hold.
        cycle(1'b0, 32'h0, H_WAIT, 1'b1);
        saved_rdata = ibus_rdata_i;
        check_bit("hold0_valid", inst_valid_o, 1'b0);
        check_bit("hold0_req",   ibus_req_o,   1'b0);
        cycle(1'b0, 32'h0, H_WAIT, 1'b0);
        check_bit("hold1_valid", inst_valid_o, 1'b0);
        cycle(1'b0, 32'h0, H_WAIT, 1'b0);
        check_bit("hold2_valid", inst_valid_o, 1'b0);
        cycle(1'b0, 32'h0, H_NO, 1'b0);
        check_bit("rel_valid", inst_valid_o, 1'b1);
        check    ("rel_iaddr", inst_addr_o,  32'h10);
        check    ("rel_data",  inst_o,       saved_rdata);
        check_bit("rel_req",   ibus_req_o,   1'b1);
        check    ("rel_addr",  ibus_addr_o,  32'h14);

        // Jump with ack to 0x40, then jump to 0x203 while 0x40 is outstanding.
        cycle(1'b1, 32'h40, H_NO, 1'b1);
        check_bit("j40_valid", inst_valid_o, 1'b0);
        check    ("j40_addr",  ibus_addr_o,  32'h40);
        cycle(1'b1, 32'h203, H_NO, 1'b0);
        check    ("disc_addr", ibus_addr_o,  32'h40);
        check_bit("disc_req",  ibus_req_o,   1'b1);
        cycle(1'b0, 32'h0, H_NO, 1'b0);
        check_bit("disc1_valid", inst_valid_o, 1'b0);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check_bit("disc_ack_valid", inst_valid_o, 1'b0);
        check    ("redir_addr",     ibus_addr_o,  32'h200);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check    ("redir_iaddr",    inst_addr_o,  32'h200);

        // Jump coinciding with the ack of 0x8.
        do_reset(1);
        cycle(1'b0, 32'h0, H_NO, 1'b0);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check    ("pc_8", ibus_addr_o, 32'h8);
        cycle(1'b1, 32'h100, H_NO, 1'b1);
        check_bit("j100_valid", inst_valid_o, 1'b0);
        check    ("j100_addr",  ibus_addr_o,  32'h100);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check    ("j100_iaddr", inst_addr_o,  32'h100);

        // Target alignment and wrap at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFFF, H_NO, 1'b1);
        check    ("top_addr", ibus_addr_o, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check    ("top_iaddr", inst_addr_o, 32'hFFFF_FFFC);
        check    ("wrap_addr", ibus_addr_o, 32'h0);

        // Latest pending jump wins.
        cycle(1'b1, 32'h300, H_NO, 1'b0);
        cycle(1'b1, 32'h400, H_NO, 1'b0);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check_bit("latest_valid", inst_valid_o, 1'b0);
        check    ("latest_addr",  ibus_addr_o,  32'h400);

        // Bus timeout: ack withheld.
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) cycle(1'b0, 32'h0, H_NO, 1'b0);
        check_bit("tmo_before", fetch_err_o, 1'b0);
        cycle(1'b0, 32'h0, H_NO, 1'b0);
        check_bit("tmo_hit", fetch_err_o, TMO_EXP);
        check    ("tmo_addr", ibus_addr_o, 32'h400);
        cycle(1'b0, 32'h0, H_NO, 1'b1);
        check_bit("tmo_sticky", fetch_err_o, TMO_EXP);
        do_reset(1);
        check_bit("tmo_cleared", fetch_err_o, 1'b0);

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle($urandom_range(0, 5) == 0, $urandom(),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
